// File: rtl/a0_trace_pkg.sv
// ---------------------------------------------------------------------------
// a0_trace_pkg
// Shared constants and entry typing for the a0 trace buffer.
// Optional feature macro: A0_TRACE_TIMESTAMP_EN (adds a timestamp to each
// entry; widens entries to TS_WIDTH+DATA_WIDTH).
// ---------------------------------------------------------------------------
package a0_trace_pkg;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_DEPTH      = 16;
  localparam int DEFAULT_TS_WIDTH   = 32;
  localparam int DROP_CNT_W         = 16;

`ifdef A0_TRACE_TIMESTAMP_EN
  localparam bit TS_EN = 1'b1;
`else
  localparam bit TS_EN = 1'b0;
`endif

  // Width of one stored trace entry.
  function automatic int entry_width(input int data_width, input int ts_width);
    return TS_EN ? (data_width + ts_width) : data_width;
  endfunction

`ifdef A0_TRACE_TIMESTAMP_EN
  typedef struct packed {
    logic [DEFAULT_TS_WIDTH-1:0]   ts;
    logic [DEFAULT_DATA_WIDTH-1:0] a0;
  } trace_entry_t;
`else
  typedef logic [DEFAULT_DATA_WIDTH-1:0] trace_entry_t;
`endif

endpackage

// File: rtl/a0_trace_if.sv
// ---------------------------------------------------------------------------
// a0_trace_if
// Bundles the observer-side inputs (a0 sample, capture enable, clear) and the
// consumer-side valid/ready drain port of the a0 trace buffer.
//   master : producer/consumer side (drives a0, capture_en, clear, out_ready)
//   slave  : trace buffer side (drives out_valid, out_data, level, overflow,
//            drop_count)
// ---------------------------------------------------------------------------
interface a0_trace_if
  import a0_trace_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int DEPTH      = DEFAULT_DEPTH,
  parameter int TS_WIDTH   = DEFAULT_TS_WIDTH,
  localparam int ENTRY_W   = entry_width(DATA_WIDTH, TS_WIDTH),
  localparam int LEVEL_W   = $clog2(DEPTH) + 1
) ();

  logic [DATA_WIDTH-1:0] a0;
  logic                  capture_en;
  logic                  clear;
  logic                  out_valid;
  logic                  out_ready;
  logic [ENTRY_W-1:0]    out_data;
  logic [LEVEL_W-1:0]    level;
  logic                  overflow;
  logic [DROP_CNT_W-1:0] drop_count;

  modport master (
    output a0, capture_en, clear, out_ready,
    input  out_valid, out_data, level, overflow, drop_count
  );

  modport slave (
    input  a0, capture_en, clear, out_ready,
    output out_valid, out_data, level, overflow, drop_count
  );

endinterface

// File: rtl/trace_fifo.sv
// ---------------------------------------------------------------------------
// trace_fifo
// Generic synchronous FIFO. Read data is combinational from storage at the
// read pointer (no fall-through). A push while full is dropped unless a pop
// happens in the same cycle. Clear empties the FIFO and wins over push/pop.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   i_clear    synchronous flush
//   i_push     write i_wdata (dropped when full and not popping)
//   i_pop      consume head entry (ignored when empty)
//   o_rdata    head entry (don't-care when empty)
//   o_full     level == DEPTH
//   o_empty    level == 0
//   o_level    current occupancy
// ---------------------------------------------------------------------------
module trace_fifo #(
  parameter int  WIDTH   = 32,
  parameter int  DEPTH   = 16,
  localparam int ADDR_W  = $clog2(DEPTH),
  localparam int LEVEL_W = ADDR_W + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_clear,
  input  logic               i_push,
  input  logic               i_pop,
  input  logic [WIDTH-1:0]   i_wdata,
  output logic [WIDTH-1:0]   o_rdata,
  output logic               o_full,
  output logic               o_empty,
  output logic [LEVEL_W-1:0] o_level
);

  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic [ADDR_W-1:0]  r_wr_ptr;
  logic [ADDR_W-1:0]  r_rd_ptr;
  logic [LEVEL_W-1:0] r_level;
  logic [LEVEL_W-1:0] w_level_nxt;
  logic               w_do_push;
  logic               w_do_pop;

  assign o_full    = (r_level == LEVEL_W'(DEPTH));
  assign o_empty   = (r_level == '0);
  assign o_level   = r_level;
  assign o_rdata   = r_mem[r_rd_ptr];

  assign w_do_pop  = i_pop & ~o_empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign w_do_push = i_push & (~o_full | w_do_pop);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    w_level_nxt = r_level;
    case ({w_do_push, w_do_pop})
      2'b10:   w_level_nxt = r_level + LEVEL_W'(1);
      2'b01:   w_level_nxt = r_level - LEVEL_W'(1);
      default: w_level_nxt = r_level;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
      r_level <= w_level_nxt;
    end
  end

  // NOTE: the storage array is deliberately not reset; pointers and level
  // define which words are meaningful, and an unreset array maps onto RAM.
  always_ff @(posedge clk) begin
    if (w_do_push && !i_clear) r_mem[r_wr_ptr] <= i_wdata;
  end

endmodule

// File: rtl/a0_trace_buffer.sv
// ---------------------------------------------------------------------------
// a0_trace_buffer
// Observes the core's a0 output every cycle and queues each new value so a
// slower consumer can drain it over valid/ready without losing transitions.
// Optional feature macro: A0_TRACE_TIMESTAMP_EN -- adds a free-running cycle
// counter; each entry becomes {timestamp_at_sample_edge, a0}.
// Ports:
//   clk               single clock
//   rst               synchronous active-high reset
//   bus (slave)       a0, capture_en, clear in; out_valid/out_ready/out_data
//                     drain port; level, overflow (sticky), drop_count (sat.)
// ---------------------------------------------------------------------------
module a0_trace_buffer
  import a0_trace_pkg::*;
#(
  parameter int  DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int  DEPTH      = DEFAULT_DEPTH,
  parameter int  TS_WIDTH   = DEFAULT_TS_WIDTH,
  localparam int ENTRY_W    = entry_width(DATA_WIDTH, TS_WIDTH),
  localparam int LEVEL_W    = $clog2(DEPTH) + 1
) (
  input logic        clk,
  input logic        rst,
  a0_trace_if.slave  bus
);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("a0_trace_buffer: DEPTH must be a power of 2 and >= 2");
  end

  localparam logic [DROP_CNT_W-1:0] DROP_ONE = DROP_CNT_W'(1);

  logic [DATA_WIDTH-1:0] r_prev_a0;
  logic                  r_prev_valid;
  logic                  r_overflow;
  logic [DROP_CNT_W-1:0] r_drop_count;

  logic                  w_push;
  logic                  w_pop;
  logic                  w_drop;
  logic                  w_full;
  logic                  w_empty;
  logic [LEVEL_W-1:0]    w_level;
  logic [ENTRY_W-1:0]    w_entry;
  logic [ENTRY_W-1:0]    w_head;

  // Only changes are recorded; the first sample after reset/clear always is.
  assign w_push = bus.capture_en & (~r_prev_valid | (bus.a0 != r_prev_a0));
  assign w_pop  = ~w_empty & bus.out_ready;
  assign w_drop = w_push & w_full & ~w_pop;

`ifdef A0_TRACE_TIMESTAMP_EN
  logic [TS_WIDTH-1:0] r_ts;

  always_ff @(posedge clk) begin
    if (rst || bus.clear) r_ts <= '0;
    else                  r_ts <= r_ts + TS_WIDTH'(1);
  end

  // The counter value before the edge is the timestamp of that sample edge.
  assign w_entry = {r_ts, bus.a0};
`else
  assign w_entry = bus.a0;
`endif

  trace_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_clear (bus.clear),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_wdata (w_entry),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (w_level)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev_a0    <= '0;
      r_prev_valid <= 1'b0;
      r_overflow   <= 1'b0;
      r_drop_count <= '0;
    end else if (bus.clear) begin
      r_prev_valid <= 1'b0;
      r_overflow   <= 1'b0;
      r_drop_count <= '0;
    end else begin
      // The reference value tracks every capture, even when the push is dropped.
      if (bus.capture_en) begin
        r_prev_a0    <= bus.a0;
        r_prev_valid <= 1'b1;
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
        if (r_drop_count != '1) r_drop_count <= r_drop_count + DROP_ONE;
      end
    end
  end

  assign bus.out_valid  = ~w_empty;
  assign bus.out_data   = w_head;
  assign bus.level      = w_level;
  assign bus.overflow   = r_overflow;
  assign bus.drop_count = r_drop_count;

endmodule

// File: tb/tb_a0_trace_buffer.sv
module tb_a0_trace_buffer;
  import a0_trace_pkg::*;

  localparam int DW      = 32;
  localparam int DEPTH   = 16;
  localparam int TSW     = 32;
  localparam int ENTRY_W = entry_width(DW, TSW);

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  a0_trace_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .TS_WIDTH(TSW)) bus ();

  a0_trace_buffer #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .TS_WIDTH(TSW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock edge; inputs are then driven / outputs sampled 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst            = 1'b1;
    bus.a0         = '0;
    bus.capture_en = 1'b0;
    bus.clear      = 1'b0;
    bus.out_ready  = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  // Check head value, then pop it with capture disabled.
  task automatic expect_pop(input string name, input logic [DW-1:0] val);
    check({name, "_valid"}, 64'(bus.out_valid), 64'd1);
    check({name, "_data"}, 64'(bus.out_data[DW-1:0]), 64'(val));
    bus.capture_en = 1'b0;
    bus.out_ready  = 1'b1;
    step();
    bus.out_ready  = 1'b0;
  endtask

  // ---------------- reference model (queue of entries) ----------------
  logic [ENTRY_W-1:0]    m_q[$];
  logic                  m_pv;
  logic [DW-1:0]         m_pa;
  logic                  m_ov;
  int                    m_dc;
`ifdef A0_TRACE_TIMESTAMP_EN
  logic [TSW-1:0]        m_ts;
`endif

  task automatic model_reset();
    m_q.delete();
    m_pv = 1'b0;
    m_pa = '0;
    m_ov = 1'b0;
    m_dc = 0;
`ifdef A0_TRACE_TIMESTAMP_EN
    m_ts = '0;
`endif
  endtask

  // Effect of one clock edge with the given inputs.
  task automatic model_edge(input logic [DW-1:0] a0, input logic cap, input logic clr,
                            input logic rdy);
    logic [ENTRY_W-1:0] e;
    bit push, pop;
    if (clr) begin
      m_q.delete();
      m_pv = 1'b0;
      m_ov = 1'b0;
      m_dc = 0;
`ifdef A0_TRACE_TIMESTAMP_EN
      m_ts = '0;
`endif
      return;
    end
`ifdef A0_TRACE_TIMESTAMP_EN
    e = {m_ts, a0};
    m_ts = m_ts + 1;
`else
    e = a0;
`endif
    push = cap && (!m_pv || a0 != m_pa);
    pop  = (m_q.size() > 0) && rdy;
    if (pop) void'(m_q.pop_front());
    if (push) begin
      if (m_q.size() < DEPTH) m_q.push_back(e);
      else begin
        m_ov = 1'b1;
        if (m_dc < 16'hFFFF) m_dc++;
      end
    end
    if (cap) begin
      m_pa = a0;
      m_pv = 1'b1;
    end
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic [DW-1:0] a0;
    logic          cap;
    logic          clr;
    logic          rdy;
    int            exp_level;
    logic          exp_valid;
    logic [DW-1:0] exp_head;
  } vec_t;

  vec_t vecs[12];

  initial begin
    vecs[0]  = '{5, 1, 0, 0, 1, 1, 5};  // first sample always pushed
    vecs[1]  = '{5, 1, 0, 0, 1, 1, 5};  // stable a0: nothing new
    vecs[2]  = '{5, 0, 0, 0, 1, 1, 5};
    vecs[3]  = '{7, 0, 0, 0, 1, 1, 5};  // change while not capturing: lost
    vecs[4]  = '{7, 1, 0, 0, 2, 1, 5};
    vecs[5]  = '{7, 1, 0, 1, 1, 1, 7};  // pop only
    vecs[6]  = '{9, 1, 0, 1, 1, 1, 9};  // push + pop
    vecs[7]  = '{9, 1, 0, 1, 0, 0, 0};  // drained
    vecs[8]  = '{9, 1, 1, 0, 0, 0, 0};  // clear
    vecs[9]  = '{9, 1, 0, 0, 1, 1, 9};  // same value re-pushed after clear
    vecs[10] = '{5, 1, 1, 0, 0, 0, 0};  // clear-cycle sample discarded
    vecs[11] = '{5, 1, 0, 0, 1, 1, 5};

    // Reset state
    do_reset();
    check("rst_valid", 64'(bus.out_valid), 64'd0);
    check("rst_level", 64'(bus.level), 64'd0);
    check("rst_overflow", 64'(bus.overflow), 64'd0);
    check("rst_drop", 64'(bus.drop_count), 64'd0);

    for (int i = 0; i < 12; i++) begin
      bus.a0         = vecs[i].a0;
      bus.capture_en = vecs[i].cap;
      bus.clear      = vecs[i].clr;
      bus.out_ready  = vecs[i].rdy;
      step();
      check($sformatf("vec%0d_level", i), 64'(bus.level), 64'(vecs[i].exp_level));
      check($sformatf("vec%0d_valid", i), 64'(bus.out_valid), 64'(vecs[i].exp_valid));
      if (vecs[i].exp_valid)
        check($sformatf("vec%0d_head", i), 64'(bus.out_data[DW-1:0]), 64'(vecs[i].exp_head));
    end
    bus.clear = 1'b0;

    // Sequence 1,2,2,3,1 -> four entries, A->B->A style repeats kept
    do_reset();
    begin
      logic [DW-1:0] seq[5];
      seq = '{1, 2, 2, 3, 1};
      bus.capture_en = 1'b1;
      for (int i = 0; i < 5; i++) begin
        bus.a0 = seq[i];
        step();
      end
    end
    check("seq_level", 64'(bus.level), 64'd4);
    expect_pop("seq0", 1);
    expect_pop("seq1", 2);
    expect_pop("seq2", 3);
    expect_pop("seq3", 1);
    check("seq_empty", 64'(bus.out_valid), 64'd0);

    // Overflow: 20 distinct values into 16 entries
    do_reset();
    bus.capture_en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      bus.a0 = DW'(100 + i);
      step();
    end
    check("ovf_level", 64'(bus.level), 64'd16);
    check("ovf_flag", 64'(bus.overflow), 64'd1);
    check("ovf_drops", 64'(bus.drop_count), 64'd4);
    for (int i = 0; i < 16; i++) expect_pop($sformatf("ovf_drain%0d", i), DW'(100 + i));
    check("ovf_empty", 64'(bus.out_valid), 64'd0);

    // Full with simultaneous push and pop: no drop
    do_reset();
    bus.capture_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      bus.a0 = DW'(200 + i);
      step();
    end
    check("fullpp_pre", 64'(bus.level), 64'd16);
    bus.a0        = 300;
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    check("fullpp_level", 64'(bus.level), 64'd16);
    check("fullpp_ovf", 64'(bus.overflow), 64'd0);
    check("fullpp_drop", 64'(bus.drop_count), 64'd0);
    for (int i = 1; i < 16; i++) expect_pop($sformatf("fullpp_drain%0d", i), DW'(200 + i));
    expect_pop("fullpp_tail", 300);

    // Clear at level 7 while a0 changes
    do_reset();
    bus.capture_en = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      bus.a0 = DW'(i);
      step();
    end
    check("clr_pre", 64'(bus.level), 64'd7);
    bus.a0    = 50;
    bus.clear = 1'b1;
    step();
    bus.clear = 1'b0;
    check("clr_level", 64'(bus.level), 64'd0);
    check("clr_ovf", 64'(bus.overflow), 64'd0);
    check("clr_valid", 64'(bus.out_valid), 64'd0);
    bus.a0 = 51;
    step();
    check("clr_next_level", 64'(bus.level), 64'd1);
    check("clr_next_head", 64'(bus.out_data[DW-1:0]), 64'd51);

    // Reset in mid-drain
    do_reset();
    bus.capture_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.a0 = DW'(60 + i);
      step();
    end
    bus.capture_en = 1'b0;
    bus.out_ready  = 1'b1;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.out_ready = 1'b0;
    step();
    check("mrst_valid", 64'(bus.out_valid), 64'd0);
    check("mrst_level", 64'(bus.level), 64'd0);

`ifdef A0_TRACE_TIMESTAMP_EN
    // Timestamps: a0 changes at sample edges 3 and 10 after reset
    do_reset();
    bus.capture_en = 1'b1;
    for (int k = 0; k < 12; k++) begin
      bus.a0 = (k >= 10) ? DW'(22) : (k >= 3) ? DW'(11) : DW'(0);
      step();
    end
    bus.capture_en = 1'b0;
    check("ts_level", 64'(bus.level), 64'd3);
    check("ts0", 64'(bus.out_data[ENTRY_W-1:DW]), 64'd0);
    expect_pop("ts0_a0", 0);
    check("ts1", 64'(bus.out_data[ENTRY_W-1:DW]), 64'd3);
    expect_pop("ts1_a0", 11);
    check("ts2", 64'(bus.out_data[ENTRY_W-1:DW]), 64'd10);
    expect_pop("ts2_a0", 22);
`endif

    // Randomized run against the queue model
    do_reset();
    model_reset();
    for (int i = 0; i < 3000; i++) begin
      logic [DW-1:0] a;
      logic c, k, r;
      a = DW'($urandom_range(0, 3));
      c = ($urandom_range(0, 9) != 0);
      k = ($urandom_range(0, 149) == 0);
      // Alternate slow and fast consumer phases to reach full and empty.
      r = ((i / 300) % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      bus.a0         = a;
      bus.capture_en = c;
      bus.clear      = k;
      bus.out_ready  = r;
      model_edge(a, c, k, r);
      step();
      check("rnd_valid", 64'(bus.out_valid), 64'(m_q.size() > 0));
      check("rnd_level", 64'(bus.level), 64'(m_q.size()));
      check("rnd_ovf", 64'(bus.overflow), 64'(m_ov));
      check("rnd_drop", 64'(bus.drop_count), 64'(m_dc));
      if (m_q.size() > 0) check("rnd_data", 64'(bus.out_data), 64'(m_q[0]));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
